// File: rtl/cache_ctrl.sv
// Cache controller between the memory stage and a direct-mapped storage array.
// Write-back / write-allocate with word-serial memory refill.
module cache_ctrl #(
    parameter int ADDR_BITS  = 32,
    parameter int TAG_BITS   = 22,
    parameter int WORD_BITS  = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic                 cpu_inv,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic [WORD_BITS-1:0] cpu_din,
    output logic [WORD_BITS-1:0] cpu_dout,
    output logic                 cpu_stall,
    output logic [ADDR_BITS-1:0] cache_addr,
    output logic                 cache_load,
    output logic                 cache_edit,
    output logic                 cache_invalid,
    output logic [WORD_BITS-1:0] cache_din,
    input  logic                 cache_hit,
    input  logic                 cache_valid,
    input  logic                 cache_dirty,
    input  logic [TAG_BITS-1:0]  cache_tag,
    input  logic [WORD_BITS-1:0] cache_dout,
    output logic                 mem_cs,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [WORD_BITS-1:0] mem_dout,
    input  logic [WORD_BITS-1:0] mem_din,
    input  logic                 mem_ack
);

    localparam int OFS_BITS = $clog2(LINE_WORDS);
    localparam int IDX_BITS = ADDR_BITS - TAG_BITS - OFS_BITS - 2;

    typedef enum logic [2:0] {IDLE, BACK, FILL, INV, WAIT} state_t;

    state_t                state, state_d;
    logic [OFS_BITS-1:0]   word_cnt, cnt_d;
    logic [ADDR_BITS-1:0]  lat_addr;
    logic                  op_inv;
    logic [TAG_BITS-1:0]   vic_tag;

    logic [TAG_BITS-1:0]   cpu_tag;
    logic [TAG_BITS-1:0]   lat_tag;
    logic [IDX_BITS-1:0]   lat_idx;
    logic                  inv_back;
    logic                  last_word;

    assign cpu_tag   = cpu_addr[ADDR_BITS-1 -: TAG_BITS];
    assign lat_tag   = lat_addr[ADDR_BITS-1 -: TAG_BITS];
    assign lat_idx   = lat_addr[ADDR_BITS-TAG_BITS-1 -: IDX_BITS];
    assign inv_back  = cache_valid && cache_dirty && (cache_tag == cpu_tag);
    assign last_word = (word_cnt == OFS_BITS'(LINE_WORDS - 1));

    // Victim tag is captured on the miss cycle; the line is untouched until refill.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            word_cnt <= '0;
            lat_addr <= '0;
            op_inv   <= 1'b0;
            vic_tag  <= '0;
        end else begin
            state    <= state_d;
            word_cnt <= cnt_d;
            if (state == IDLE && state_d != IDLE) begin
                lat_addr <= cpu_addr;
                op_inv   <= cpu_inv;
                vic_tag  <= cache_tag;
            end
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = word_cnt;
        unique case (state)
            IDLE: begin
                if (cpu_inv) begin
                    if (inv_back) begin
                        state_d = BACK;
                        cnt_d   = '0;
                    end
                end else if (cpu_req && !cache_hit) begin
                    state_d = (cache_valid && cache_dirty) ? BACK : FILL;
                    cnt_d   = '0;
                end
            end
            BACK: begin
                if (mem_ack) begin
                    cnt_d = word_cnt + OFS_BITS'(1);
                    if (last_word) state_d = op_inv ? INV : FILL;
                end
            end
            FILL: begin
                if (mem_ack) begin
                    cnt_d = word_cnt + OFS_BITS'(1);
                    if (last_word) state_d = WAIT;
                end
            end
            INV:     state_d = IDLE;
            WAIT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cpu_dout      = '0;
        cpu_stall     = 1'b0;
        cache_addr    = '0;
        cache_load    = 1'b0;
        cache_edit    = 1'b0;
        cache_invalid = 1'b0;
        cache_din     = '0;
        mem_cs        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_dout      = '0;
        unique case (state)
            IDLE: begin
                cache_addr = cpu_addr;
                if (cpu_inv) begin
                    if (inv_back) cpu_stall = 1'b1;
                    else cache_invalid = 1'b1;
                end else if (cpu_req) begin
                    if (!cache_hit) begin
                        cpu_stall = 1'b1;
                    end else if (cpu_we) begin
                        cache_edit = 1'b1;
                        cache_din  = cpu_din;
                    end else begin
                        cpu_dout = cache_dout;
                    end
                end
            end
            BACK: begin
                cpu_stall  = 1'b1;
                mem_cs     = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = {vic_tag, lat_idx, word_cnt, 2'b00};
                cache_addr = {vic_tag, lat_idx, word_cnt, 2'b00};
                mem_dout   = cache_dout;
            end
            FILL: begin
                cpu_stall  = 1'b1;
                mem_cs     = 1'b1;
                mem_addr   = {lat_tag, lat_idx, word_cnt, 2'b00};
                cache_addr = {lat_tag, lat_idx, word_cnt, 2'b00};
                if (mem_ack) begin
                    cache_load = 1'b1;
                    cache_din  = mem_din;
                end
            end
            INV: begin
                cpu_stall     = 1'b1;
                cache_addr    = lat_addr;
                cache_invalid = 1'b1;
            end
            WAIT:    cpu_stall = 1'b1;
            default: ;
        endcase
    end

endmodule
